// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
//   Serial-to-parallel UART receiver. Frame format: 1 start bit (low),
//   DATA_WIDTH data bits LSB first, 1 stop bit (high). Bit timing comes from a
//   shared 16x-oversampling baudTick strobe.
//
//   The start bit is confirmed at its centre (8 ticks after the falling edge).
//   From then on every bit is sampled 16 ticks later, which lands on the centre
//   of each following bit.
//
//   Optional feature (macro UART_RX_MAJORITY_EN):
//     defined     - data and stop bits are decided by a 2-of-3 majority of the
//                   synchronised line captured on the baudTicks at tick 13, 14
//                   and 15. The start-bit check is unchanged.
//     not defined - data and stop bits use a single sample at tick 15.
//   The port list is the same in both builds.
//
// Ports
//   clk        in   1           system clock, all logic on posedge
//   rstN       in   1           asynchronous, active-low reset
//   rx         in   1           serial line, idle high, asynchronous to clk
//   baudTick   in   1           1-clk strobe, 16 per bit period
//   dataOut    out  DATA_WIDTH  last correctly framed word, held until the
//                               next good frame
//   rx_done    out  1           1-clk pulse: dataOut updated this cycle
//   frame_err  out  1           1-clk pulse: stop bit sampled low, word dropped
//   rx_busy    out  1           high in any state other than idle
//
// Handshake: rx_done and frame_err are single-cycle strobes with no ready/back
//   pressure; the consumer must capture dataOut in the cycle rx_done is high
//   (dataOut stays valid until the next good frame). The two strobes are never
//   high together.
//
// The FSM state is held in state_q so checkers can bind to it directly.
// -----------------------------------------------------------------------------
module uart_receiver #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  rx,
    input  logic                  baudTick,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  rx_done,
    output logic                  frame_err,
    output logic                  rx_busy
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            rx_sync_q, rx_sync_d;
    logic [3:0]            tick_q, tick_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic rx_s;        // synchronised serial line
    logic bit_val;     // decided value of the current data/stop bit
    logic centre_tick; // baudTick that lands on a data/stop bit centre
    logic start_tick;  // baudTick that lands on the start bit centre

    // -------------------------------------------------------------------------
    // Two-flop synchroniser; resets to the idle (high) line level so a reset
    // never looks like a start bit.
    // -------------------------------------------------------------------------
    assign rx_sync_d = {rx_sync_q[0], rx};
    assign rx_s      = rx_sync_q[1];

    assign centre_tick = baudTick && (tick_q == 4'd15);
    assign start_tick  = baudTick && (tick_q == 4'd7);

`ifdef UART_RX_MAJORITY_EN
    // Samples taken at tick 13 and 14; tick 15 uses the live rx_s.
    logic samp13_q, samp13_d;
    logic samp14_q, samp14_d;

    always_comb begin
        samp13_d = samp13_q;
        samp14_d = samp14_q;
        if (baudTick && (state_q == ST_DATA || state_q == ST_STOP)) begin
            if (tick_q == 4'd13) begin
                samp13_d = rx_s;
            end
            if (tick_q == 4'd14) begin
                samp14_d = rx_s;
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            samp13_q <= 1'b1;
            samp14_q <= 1'b1;
        end else begin
            samp13_q <= samp13_d;
            samp14_q <= samp14_d;
        end
    end

    assign bit_val = (samp13_q & samp14_q) | (samp13_q & rx_s) | (samp14_q & rx_s);
`else
    assign bit_val = rx_s;
`endif

    // -------------------------------------------------------------------------
    // FSM process 1: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM process 2: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                // A line that is high again at the start-bit centre was noise.
                if (start_tick) begin
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (centre_tick && (count_q == LAST_BIT)) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (centre_tick) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM process 3: outputs and datapath next values
    // -------------------------------------------------------------------------
    always_comb begin
        tick_d  = tick_q;
        count_d = count_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    tick_d = 4'd0;
                end
            end
            ST_START: begin
                if (baudTick) begin
                    if (tick_q == 4'd7) begin
                        tick_d  = 4'd0;
                        count_d = '0;
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
            end
            ST_DATA: begin
                if (baudTick) begin
                    // 15 -> 0 wrap lines the counter up for the next bit centre.
                    tick_d = tick_q + 4'd1;
                end
                if (centre_tick) begin
                    // LSB arrives first, so shifting in from the top leaves it
                    // in bit 0 once the whole word has been received.
                    shreg_d = {bit_val, shreg_q[DATA_WIDTH-1:1]};
                    count_d = count_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (baudTick) begin
                    tick_d = tick_q + 4'd1;
                end
                if (centre_tick) begin
                    if (bit_val) begin
                        data_d = shreg_q;
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                tick_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rx_sync_q <= 2'b11;
            tick_q    <= 4'd0;
            count_q   <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            rx_sync_q <= rx_sync_d;
            tick_q    <= tick_d;
            count_q   <= count_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign dataOut   = data_q;
    assign rx_done   = done_q;
    assign frame_err = err_q;
    assign rx_busy   = (state_q != ST_IDLE);

endmodule
